// File: rtl/shift_sequencer_if.sv
// Command/status bundle for shift_sequencer: the requester drives the command
// fields, the sequencer drives status and register contents.
interface shift_sequencer_if #(
  parameter int WIDTH       = 4,
  parameter int COUNT_WIDTH = 3
);
  logic                   start;
  logic [1:0]             mode;
  logic [COUNT_WIDTH-1:0] amount;
  logic [WIDTH-1:0]       preset;
  logic                   serialInput;
  logic                   busy;
  logic                   done;
  logic                   carryOut;
  logic [WIDTH-1:0]       out;
  logic [WIDTH-1:0]       notout;

  modport master (
    output start, mode, amount, preset, serialInput,
    input  busy, done, carryOut, out, notout
  );

  modport slave (
    input  start, mode, amount, preset, serialInput,
    output busy, done, carryOut, out, notout
  );
endinterface

// File: rtl/shift_sequencer.sv
// Sequenced left-shift/rotate register: loads a preset on start, then performs
// a latched number of shifts one per clock, with busy/done status.
module shift_sequencer #(
  parameter int WIDTH       = 4,
  parameter int COUNT_WIDTH = 3
) (
  input  logic             clockpulse,
  input  logic             clear,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]       out_q, out_d;
  logic                   carry_q, carry_d;

  // Fill bit entering the LSB; serialInput is deliberately taken live.
  function automatic logic fill_bit(input logic [1:0] m, input logic msb, input logic si);
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return msb;
      default: return si;
    endcase
  endfunction

  always_ff @(posedge clockpulse) begin
    if (clear) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      rem_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    out_d   = out_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          rem_d   = bus.amount;
          out_d   = bus.preset;
          carry_d = 1'b0;
          state_d = (bus.amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        carry_d = out_q[WIDTH-1];
        out_d   = {out_q[WIDTH-2:0], fill_bit(mode_q, out_q[WIDTH-1], bus.serialInput)};
        rem_d   = rem_q - COUNT_WIDTH'(1);
        if (rem_q == COUNT_WIDTH'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.carryOut = carry_q;
  assign bus.out      = out_q;
  assign bus.notout   = ~out_q;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Sequenced left-shift datapath: loads a WIDTH-bit preset, then applies a programmed number of left shifts or rotates, one per clock.
- Uses a start/busy/done handshake, so lab top-levels and the FSM experiments can drive shift operations as single commands.
- Exposes the same out/notout view as the team's 4-bit left shift register.

Parameters:
- WIDTH, 4, register width in bits.
- COUNT_WIDTH, 3, width of the shift-amount field; amounts larger than WIDTH are legal.

Ports:
- clockpulse  input  1  system clock, rising edge.
- clear  input  1  synchronous, active-high reset.
- start  input  1  command request; sampled only in IDLE.
- mode  input  2  00 shift left with 0 fill; 01 shift left with 1 fill; 10 rotate left; 11 shift left with serialInput fill.
- amount  input  COUNT_WIDTH  number of shifts to perform.
- preset  input  WIDTH  value loaded at command acceptance.
- serialInput  input  1  fill bit for mode 11, sampled live on every shift edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- carryOut  output  1  bit shifted out of the MSB on the most recent shift.
- out  output  WIDTH  register contents.
- notout  output  WIDTH  ~out, combinational.

Behaviour:
- Reset: clear sampled high at a clockpulse edge forces the following values, regardless of current state.
  - state=IDLE, out=0, carryOut=0, done=0, internal counter=0.
  - busy=0 and notout=all ones.
- States are IDLE, SHIFT and DONE. busy and done are decoded from the state register, so they are glitch-free.
- IDLE:
  - On an edge with start=1, latch mode and amount, load out<=preset and carryOut<=0.
  - Next state is SHIFT with remaining<=amount, or DONE if amount==0.
  - start=0 holds all outputs unchanged.
- SHIFT: each edge performs one operation and decrements remaining.
  - carryOut<=out[WIDTH-1].
  - out<={out[WIDTH-2:0], fill}; fill is 0, 1, serialInput or out[WIDTH-1] according to the latched mode.
  - The edge on which remaining goes from 1 to 0 moves the state to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE. out and carryOut are held.
- Latency, for start accepted at edge k:
  - out=preset after edge k.
  - Shift i is visible after edge k+i.
  - done is high between edges k+amount and k+amount+1.
  - busy is high for amount+1 cycles.
- start while busy (SHIFT or DONE) is ignored, not queued. A new command can be accepted at the first edge in which the state is IDLE.
- mode, amount and preset changes while busy have no effect; they are latched at acceptance. serialInput is the only input sampled live.
- Boundary cases:
  - amount > WIDTH: shift modes saturate to the fill pattern; rotate wraps modulo WIDTH.
  - Counter width is COUNT_WIDTH, with no overflow possible.
- clear mid-operation: immediate abort to the reset values; no done pulse is produced.
- clear and start on the same edge: clear wins; the command is dropped.

Test Plan:
- Reset: clear=1 for 2 edges -> out=0000, notout=1111, busy=0, done=0, carryOut=0.
- Shift with zero fill: mode=00, preset=0011, amount=3.
  - out sequence after edges k..k+3: 0011, 0110, 1100, 1000.
  - carryOut=1 after edge k+3; done high only during cycle k+3..k+4; busy high for 4 cycles.
- Rotate: mode=10, preset=1001, amount=5.
  - out sequence: 1001, 0011, 0110, 1100, 1001, 0011.
  - Final carryOut=1, single done pulse.
- Zero amount: mode=00, preset=1010, amount=0 -> out=1010 after edge k; done high in the next cycle; busy for 1 cycle; carryOut=0.
- Serial and one fill:
  - mode=11, preset=0000, amount=4, serialInput=1,0,1,1 on the shift edges -> out=1011.
  - mode=01, preset=0000, amount=2 -> out=0011.
- Abort and ignore:
  - start pulsed again during SHIFT (with a different preset) -> ignored; the result matches the first command.
  - clear asserted after the 2nd shift -> out=0000, busy=0 on the next cycle, no done pulse.
  - start plus clear on the same edge -> stays IDLE.
